// File: rtl/line_pingpong_buf_if.sv
// Stream bundle for line_pingpong_buf: pixel input side, line output side and status pulses.
// MIRROR is present only when LINE_MIRROR_EN is defined.
interface line_pingpong_buf_if #(
    parameter int unsigned DATA_W = 14
);
    logic              IN_VALID;
    logic              IN_SOL;
    logic [DATA_W-1:0] DATA_IN;
    logic              OUT_READY;
    logic              OUT_VALID;
    logic [DATA_W-1:0] DATA_OUT;
    logic              OUT_EOL;
    logic              OUT_BANK;
    logic              LINE_DROP;
    logic              SHORT_LINE;
    logic [1:0]        BANKS_FULL;
`ifdef LINE_MIRROR_EN
    logic              MIRROR;

    modport slave (
        input  IN_VALID, IN_SOL, DATA_IN, OUT_READY, MIRROR,
        output OUT_VALID, DATA_OUT, OUT_EOL, OUT_BANK, LINE_DROP, SHORT_LINE, BANKS_FULL
    );
    modport master (
        output IN_VALID, IN_SOL, DATA_IN, OUT_READY, MIRROR,
        input  OUT_VALID, DATA_OUT, OUT_EOL, OUT_BANK, LINE_DROP, SHORT_LINE, BANKS_FULL
    );
`else
    modport slave (
        input  IN_VALID, IN_SOL, DATA_IN, OUT_READY,
        output OUT_VALID, DATA_OUT, OUT_EOL, OUT_BANK, LINE_DROP, SHORT_LINE, BANKS_FULL
    );
    modport master (
        output IN_VALID, IN_SOL, DATA_IN, OUT_READY,
        input  OUT_VALID, DATA_OUT, OUT_EOL, OUT_BANK, LINE_DROP, SHORT_LINE, BANKS_FULL
    );
`endif
endinterface

// File: rtl/line_pingpong_buf.sv
// Ping-pong line buffer: one bank fills from the ADC stream while the other streams out.
// Optional LINE_MIRROR_EN adds per-line descending readout selected by MIRROR.
module line_pingpong_buf #(
    parameter int unsigned DATA_W   = 14,
    parameter int unsigned LINE_LEN = 320
) (
    input logic                CLK,
    input logic                RESET,
    line_pingpong_buf_if.slave bus
);
    localparam int unsigned       ADDR_W   = $clog2(LINE_LEN);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(LINE_LEN - 1);

    typedef enum logic [1:0] {StWaitSol, StFill, StDrop} wr_state_e;
    typedef enum logic {StIdle, StStream} rd_state_e;

    logic [DATA_W-1:0] mem_q [2][LINE_LEN];

    wr_state_e         wr_state_q, wr_state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_en, set_full, sol;
    logic              line_drop_q, line_drop_d;
    logic              short_line_q, short_line_d;
    logic [1:0]        full_q, full_d;
    logic [1:0]        bank_mirror;

    rd_state_e         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_eol_q, out_eol_d;
    logic              out_bank_q, out_bank_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              clr_full, other_bank;
    logic [ADDR_W-1:0] start_cur, start_other;

    assign sol        = bus.IN_VALID & bus.IN_SOL;
    assign other_bank = ~out_bank_q;

`ifdef LINE_MIRROR_EN
    logic [1:0] mirror_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            mirror_q <= '0;
        end else if (set_full) begin
            mirror_q[wr_bank_q] <= bus.MIRROR;
        end
    end
    assign bank_mirror = mirror_q;
`else
    assign bank_mirror = 2'b00;
`endif

    assign start_cur   = bank_mirror[out_bank_q] ? LastAddr : '0;
    assign start_other = bank_mirror[other_bank] ? LastAddr : '0;

    // Write side
    always_comb begin
        wr_state_d   = wr_state_q;
        wr_bank_d    = wr_bank_q;
        wr_ptr_d     = wr_ptr_q;
        wr_addr      = wr_ptr_q;
        wr_en        = 1'b0;
        set_full     = 1'b0;
        line_drop_d  = 1'b0;
        short_line_d = 1'b0;

        case (wr_state_q)
            StFill: begin
                if (sol) begin
                    short_line_d = 1'b1;
                end else if (bus.IN_VALID) begin
                    wr_en = 1'b1;
                    if (wr_ptr_q == LastAddr) begin
                        set_full   = 1'b1;
                        wr_bank_d  = ~wr_bank_q;
                        wr_ptr_d   = '0;
                        wr_state_d = StWaitSol;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // A SOL in any state restarts the line; a partial line is simply abandoned in place.
        if (sol) begin
            if (!full_q[wr_bank_q]) begin
                wr_en      = 1'b1;
                wr_addr    = '0;
                wr_ptr_d   = ADDR_W'(1);
                wr_state_d = StFill;
            end else begin
                line_drop_d = 1'b1;
                wr_state_d  = StDrop;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            mem_q[wr_bank_q][wr_addr] <= bus.DATA_IN;
        end
    end

    // Read side; DATA_OUT is loaded straight from the bank so a held sample never stalls the pipe.
    always_comb begin
        rd_state_d  = rd_state_q;
        rd_ptr_d    = rd_ptr_q;
        rd_cnt_d    = rd_cnt_q;
        out_valid_d = out_valid_q;
        out_eol_d   = out_eol_q;
        out_bank_d  = out_bank_q;
        data_out_d  = data_out_q;
        clr_full    = 1'b0;

        case (rd_state_q)
            StIdle: begin
                if (full_q[out_bank_q]) begin
                    rd_ptr_d   = start_cur;
                    rd_cnt_d   = '0;
                    rd_state_d = StStream;
                end
            end
            StStream: begin
                if (out_valid_q && out_eol_q && bus.OUT_READY) begin
                    clr_full   = 1'b1;
                    out_bank_d = other_bank;
                    out_eol_d  = 1'b0;
                    if (full_q[other_bank]) begin
                        data_out_d = mem_q[other_bank][start_other];
                        rd_ptr_d   = bank_mirror[other_bank] ? start_other - 1'b1
                                                             : start_other + 1'b1;
                        rd_cnt_d   = ADDR_W'(1);
                    end else begin
                        out_valid_d = 1'b0;
                        rd_state_d  = StIdle;
                    end
                end else if (!out_valid_q || bus.OUT_READY) begin
                    data_out_d  = mem_q[out_bank_q][rd_ptr_q];
                    out_valid_d = 1'b1;
                    out_eol_d   = (rd_cnt_q == LastAddr);
                    rd_ptr_d    = bank_mirror[out_bank_q] ? rd_ptr_q - 1'b1 : rd_ptr_q + 1'b1;
                    rd_cnt_d    = rd_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Set and clear always target different banks, so both apply in the same cycle.
    always_comb begin
        full_d = full_q;
        if (set_full) full_d[wr_bank_q] = 1'b1;
        if (clr_full) full_d[out_bank_q] = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_state_q   <= StWaitSol;
            wr_bank_q    <= 1'b0;
            wr_ptr_q     <= '0;
            line_drop_q  <= 1'b0;
            short_line_q <= 1'b0;
            full_q       <= '0;
            rd_state_q   <= StIdle;
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            out_valid_q  <= 1'b0;
            out_eol_q    <= 1'b0;
            out_bank_q   <= 1'b0;
            data_out_q   <= '0;
        end else begin
            wr_state_q   <= wr_state_d;
            wr_bank_q    <= wr_bank_d;
            wr_ptr_q     <= wr_ptr_d;
            line_drop_q  <= line_drop_d;
            short_line_q <= short_line_d;
            full_q       <= full_d;
            rd_state_q   <= rd_state_d;
            rd_ptr_q     <= rd_ptr_d;
            rd_cnt_q     <= rd_cnt_d;
            out_valid_q  <= out_valid_d;
            out_eol_q    <= out_eol_d;
            out_bank_q   <= out_bank_d;
            data_out_q   <= data_out_d;
        end
    end

    assign bus.OUT_VALID  = out_valid_q;
    assign bus.DATA_OUT   = data_out_q;
    assign bus.OUT_EOL    = out_eol_q;
    assign bus.OUT_BANK   = out_bank_q;
    assign bus.LINE_DROP  = line_drop_q;
    assign bus.SHORT_LINE = short_line_q;
    assign bus.BANKS_FULL = {1'b0, full_q[0]} + {1'b0, full_q[1]};
endmodule
